// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential 32x32 shift-and-add multiplier using an external ALU adder
//
// Purpose: computes the low 32 bits of op_a*op_b over 32 iterations (IDLE -> COMP -> DONE).
//          Each COMP cycle presents acc/mc to an external ALU (ADD) and takes alu_out into
//          acc when the current multiplier LSB is set.
// Optional feature: define MUL_EARLY_EXIT_EN to leave COMP as soon as the remaining
//          multiplier is zero (same numeric result, shorter latency).
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op_a, op_b request and operands, sampled in IDLE only
//   busy, done        busy in COMP/DONE, done is a one-cycle pulse in DONE
//   result            product, held until the next completed operation
//   alu_a, alu_b      ALU operands (acc, mc) in COMP, zero otherwise
//   alu_op            ALU opcode, constant ADD
//   alu_out           combinational ALU result
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {S_IDLE, S_COMP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mc_q, mc_d;
  logic [31:0] mp_q, mp_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [31:0] acc_step;
  logic        early_exit;

  // Accumulator value after this cycle's iteration.
  assign acc_step = mp_q[0] ? alu_out : acc_q;

`ifdef MUL_EARLY_EXIT_EN
  assign early_exit = (mp_q == 32'd0);
`else
  assign early_exit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_COMP;
      S_COMP: if (early_exit || cnt_q == 6'd31) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          mc_d  = op_a;
          mp_d  = op_b;
          cnt_d = '0;
        end
      end
      S_COMP: begin
        if (early_exit) begin
          // Nothing left to add: publish acc without iterating.
          result_d = acc_q;
        end else begin
          acc_d = acc_step;
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
          cnt_d = cnt_q + 6'd1;
          // Last iteration: result must include this edge's add.
          if (cnt_q == 6'd31) result_d = acc_step;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    if (state_q == S_COMP) begin
      alu_a = acc_q;
      alu_b = mc_q;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed self-checking bench for alu_mul_seq
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_bad;

  int total = 0;
  int bad = 0;
  int op_viol = 0;
  int idle_viol = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_35 = 4;
  localparam int LAT_B0 = 1;
  localparam int PULSE_E = 2;
  localparam int RST_E = 3;
`else
  localparam int LAT_35 = 32;
  localparam int LAT_B0 = 32;
  localparam int PULSE_E = 10;
  localparam int RST_E = 15;
`endif

  alu_mul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  // External ALU: ADD, optionally corrupted by +1.
  always_comb alu_out = alu_a + alu_b + (alu_bad ? 32'd1 : 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (alu_op !== 3'b000) op_viol++;
    if ((!busy || done) && ((alu_a !== 32'd0) || (alu_b !== 32'd0))) idle_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Presents start for edge E0; returns at the negedge after E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watches edges first.. for done; returns edge index where DONE was entered, -1 on timeout.
  task automatic wait_done(input int first, output int de);
    de = -1;
    for (int k = first; k < first + 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        de = k;
        break;
      end
    end
  endtask

  initial begin
    int de;
    int done_seen;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; alu_bad = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    reset = 1'b0;

    launch(32'd6, 32'd0);
    wait_done(1, de);
    check("lat_b0", de, LAT_B0);
    check("res_b0", result, 32'd0);

    launch(32'd3, 32'd5);
    check("busy_e0", {31'd0, busy}, 32'd1);
    wait_done(1, de);
    check("lat_3x5", de, LAT_35);
    check("res_3x5", result, 32'd15);
    @(negedge clk);
    check("done_1cyc", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, de);
    check("lat_wrap1", de, 32);
    check("res_wrap1", result, 32'd1);

    launch(32'h0001_0000, 32'h0001_0000);
    wait_done(1, de);
    check("tmo_wrap0", {31'd0, de >= 0}, 32'd1);
    check("res_wrap0", result, 32'd0);

    // Corrupted ALU: 3*5 adds twice, each +1 -> 4 then 17.
    alu_bad = 1'b1;
    launch(32'd3, 32'd5);
    wait_done(1, de);
    check("alu_path", result, 32'd17);
    alu_bad = 1'b0;

    // Start pulse during 7*9 must be ignored.
    launch(32'd7, 32'd9);
    repeat (PULSE_E - 1) @(negedge clk);
    start = 1'b1; op_a = 32'd1; op_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    check("ign_hold", result, 32'd17);
    wait_done(PULSE_E + 1, de);
    check("tmo_ign", {31'd0, de >= 0}, 32'd1);
    check("res_7x9", result, 32'd63);

    // Reset mid-operation.
    launch(32'd7, 32'd9);
    repeat (RST_E - 1) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_nodone", done_seen, 32'd0);

    launch(32'd2, 32'd4);
    wait_done(1, de);
    check("tmo_2x4", {31'd0, de >= 0}, 32'd1);
    check("res_2x4", result, 32'd8);

    @(negedge clk);
    check("alu_op_const", op_viol, 32'd0);
    check("alu_idle_zero", idle_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be (name  direction  width  meaning), clock and reset first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply of op_a by op_b
- op_a  input  32  multiplicand, sampled when start is accepted
- op_b  input  32  multiplier, sampled when start is accepted
- busy  output  1  operation in progress; start is ignored while busy=1
- done  output  1  one-cycle pulse when result becomes valid
- result  output  32  low 32 bits of op_a*op_b, held until the next accepted start
- alu_a  output  32  ALU operand A, driven by this block
- alu_b  output  32  ALU operand B, driven by this block
- alu_op  output  3  ALU opcode, constant 3'b000 (ADD)
- alu_out  input  32  combinational ALU result for alu_a/alu_b/alu_op
REQ-003 There SHALL be no parameters; the data width is fixed at 32 bits.

Function
REQ-004 The block SHALL use three states: IDLE, COMP and DONE.
REQ-005 Internal registers SHALL be acc (32), mc (32, multiplicand), mp (32, multiplier) and cnt (6).
REQ-006 IDLE: start=1 at edge E0 SHALL load acc=0, mc=op_a, mp=op_b and cnt=0, and move to COMP.
REQ-007 busy SHALL be 1 in COMP and in DONE, and 0 in IDLE.
REQ-008 COMP, on each edge:
- acc <= alu_out if mp[0]=1, otherwise acc is held;
- mc <= mc<<1, mp <= mp>>1, cnt <= cnt+1.
REQ-009 COMP SHALL move to DONE on the edge where cnt==31, after 32 iterations (edges E1..E32).
REQ-010 alu_a SHALL equal acc and alu_b SHALL equal mc in COMP; both SHALL be 0 in IDLE and DONE.
REQ-011 alu_op SHALL be 3'b000 at all times.
REQ-012 On the transition into DONE, result SHALL be loaded with the final acc, including that edge's update.
REQ-013 done SHALL be 1 for exactly the one cycle spent in DONE.
REQ-014 DONE SHALL move to IDLE unconditionally on the next edge.
REQ-015 Without early exit, busy SHALL be high from E0 through E33, and a new start SHALL be accepted no earlier than E34.
REQ-016 Arithmetic SHALL wrap modulo 2^32; high product bits SHALL be discarded, with no overflow flag.
REQ-017 start while busy=1 SHALL be ignored and SHALL NOT disturb the operation or result.
REQ-018 result SHALL change only on entry to DONE or on reset.

Reset
REQ-019 Asserting reset at any time, including mid-COMP, SHALL immediately force:
- state=IDLE;
- busy=0, done=0, result=0;
- acc=0, mc=0, mp=0, cnt=0.
REQ-020 An aborted operation SHALL produce no done pulse.
REQ-021 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-022 Macro MUL_EARLY_EXIT_EN: when defined, in COMP with mp==0, the block SHALL move to DONE on that edge, load result=acc and perform no iteration.
REQ-023 Under MUL_EARLY_EXIT_EN, op_b=0 SHALL give DONE at E1. Numeric results SHALL be identical to the non-macro build.
REQ-024 When MUL_EARLY_EXIT_EN is undefined, latency SHALL be fixed per REQ-009/REQ-015, independent of operands.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- op_a=3, op_b=5, start at E0, macro off -> result=15, done=1 only in the cycle after E32, busy=0 after E33.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001 (wrap); op_a=0x10000, op_b=0x10000 -> result=0.
- Macro on, op_a=3, op_b=5 -> DONE entered at E4, result=15; op_b=0 -> DONE at E1, result=0.
- start pulsed at E10 during op 7*9 with op_a=1, op_b=1 -> ignored; result=63.
- reset asserted at E15 during 7*9 -> busy=0 and result=0 immediately, no done; a following start with 2*4 -> result=8.
- alu_op=3'b000 at all times; alu_a/alu_b=0 in IDLE; alu_out forced wrong in COMP -> result mismatch detected (proves the ALU path is used).
